// File: rtl/universal_shift_reg_if.sv
// Control, serial and parallel signals of the universal shift register.
// master: word source/sink driving controls; slave: the register itself.
interface universal_shift_reg_if #(
    parameter int N = 8,
    parameter int W = 1
);
    localparam int CW = $clog2(N + 1);

    logic           clr;
    logic           load;
    logic           ena;
    logic           dir;
    logic           rot;
    logic [W-1:0]   ser_in;
    logic [N*W-1:0] par_in;
    logic [N*W-1:0] par_out;
    logic [W-1:0]   ser_out;
    logic [CW-1:0]  cnt;
    logic           full;
    logic           done;

    modport master (
        output clr, load, ena, dir, rot, ser_in, par_in,
        input  par_out, ser_out, cnt, full, done
    );

    modport slave (
        input  clr, load, ena, dir, rot, ser_in, par_in,
        output par_out, ser_out, cnt, full, done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// N-stage, W-bit-lane shift register: up/down shift, rotate, load, clear.
// Ports: clk, rst (async, active-high), bus (slave side of the interface).
module universal_shift_reg #(
    parameter int N = 8,
    parameter int W = 1
) (
    input logic                  clk,
    input logic                  rst,
    universal_shift_reg_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CMAX = CW'(N);

    logic [N*W-1:0] stages;
    logic [N*W-1:0] shifted;
    logic [CW-1:0]  cnt_q;
    logic           done_q;

    // With N=1 the loops are empty and the single stage takes either
    // ser_in or itself, which covers the rotate-holds case.
    always_comb begin
        shifted = stages;
        if (!bus.dir) begin
            for (int i = N - 1; i > 0; i--) begin
                shifted[i*W +: W] = stages[(i-1)*W +: W];
            end
            shifted[0 +: W] = bus.rot ? stages[(N-1)*W +: W] : bus.ser_in;
        end else begin
            for (int i = 0; i < N - 1; i++) begin
                shifted[i*W +: W] = stages[(i+1)*W +: W];
            end
            shifted[(N-1)*W +: W] = bus.rot ? stages[0 +: W] : bus.ser_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (bus.clr) begin
            stages <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (bus.load) begin
            stages <= bus.par_in;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (bus.ena) begin
            stages <= shifted;
            if (cnt_q != CMAX) begin
                cnt_q <= cnt_q + CW'(1);
            end
            // Pulse only on the N-1 -> N transition, not while saturated.
            done_q <= (cnt_q == CMAX - CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign bus.par_out = stages;
    assign bus.ser_out = bus.dir ? stages[0 +: W] : stages[(N-1)*W +: W];
    assign bus.cnt     = cnt_q;
    assign bus.full    = (cnt_q == CMAX);
    assign bus.done    = done_q;
endmodule
